histogram_builder: RTL and testbench
====================================

Name: histogram_builder

Overview:
- Producer side of the equalisation histogram path. Streams 128-bit pixel words, counts occurrences of each 8-bit pixel value into 256 bins of 16 bits, and presents the bins as a 256x16 array.
- The array feeds the cumulative-sum/lookup block's ram[255:0] input. A one-cycle write strobe makes that block capture the finished histogram.
- Sits between the pixel memory reader and the accumulator.

Parameters:
- LANES, 8, pixel lanes per input word; lane k pixel = in_data[16k+7:16k], bits [16k+15:16k+8] ignored.
- BIN_W, 16, bin counter width.
- CNT_W, 16, width of the word-count input.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- num_words  input  CNT_W  words in frame, sampled on start; 0 is legal.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  16*LANES  packed pixel word.
- hist  output  [BIN_W-1:0] x 256  bin array, hist[v] = count of value v.
- ac_we  output  1  one-cycle strobe to the accumulator's we.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse, same cycle as ac_we.

Behaviour:
- Reset (async, any state): all bins 0, state IDLE, in_ready=0, ac_we=0, busy=0, done=0. Reset mid-frame abandons the frame; no strobe is issued.
- States: IDLE -> CLEAR -> FETCH <-> COUNT -> FLUSH -> IDLE.
- IDLE:
  - start=1: latch num_words into words_left, clear bin index, go to CLEAR.
  - start in any other state is ignored.
- CLEAR:
  - Zero one bin per cycle, index 0..255; 256 cycles.
  - Then go to FETCH if words_left!=0, else FLUSH.
- FETCH:
  - in_ready=1. Accept on in_valid&&in_ready: register in_data, lane=0, decrement words_left, go to COUNT.
  - in_ready is combinational from state only, never from in_valid.
- COUNT:
  - in_ready=0. Each cycle: hist[pix(lane)] += 1, then lane++. 8 cycles per word.
  - After lane LANES-1: go to FETCH if words_left!=0, else FLUSH.
  - Repeated values across lanes are handled naturally, since there is one increment per cycle. No read-modify-write hazard: the bin register updates before the next lane is read.
- FLUSH: ac_we=1 and done=1 for exactly one cycle, then IDLE.
- hist is stable in IDLE and holds the last frame until the next start enters CLEAR.
- Throughput: 1 word per LANES+1 cycles.
- Latency: start to done = 256 + N*(LANES+1) + 1 cycles for N words (257 for N=0).
- Arithmetic:
  - Bins are unsigned BIN_W. Overflow behaviour is set by the optional feature below.
  - words_left is unsigned CNT_W and never decrements below 0.
- in_valid while not in FETCH: the word is not consumed; the source must hold it.

Optional Feature:
- Macro: HIST_SAT_EN.
- Defined: a bin at 2^BIN_W-1 stays there on further increments (saturating). An internal sticky flag is set and cleared in CLEAR; it is debug-only and not a port.
- Not defined: bins wrap modulo 2^BIN_W (0xFFFF + 1 = 0x0000).

Test Plan:
- Reset mid-COUNT with bins non-zero -> immediately all hist=0, busy=0, in_ready=0; no done/ac_we pulse ever follows.
- start, num_words=1, lanes = values 0,1,2,...,7 -> hist[0..7]=1, all others 0; done at cycle 256+9+1 after start; ac_we coincident with done.
- start, num_words=2, all 16 lanes = 0xAB, with upper byte of each lane = 0xFF -> hist[0xAB]=16, hist[0xFF]=0, all others 0.
- in_valid held low 20 cycles in FETCH, then asserted -> in_ready stays 1, no bin changes during the stall, final counts are correct, and latency grows by exactly 20.
- num_words=0 -> all bins 0 after CLEAR; done 257 cycles after start; a start pulse during busy has no effect.
- 8193 words of all-zero pixels (65544 increments of bin 0) -> HIST_SAT_EN defined: hist[0]=0xFFFF; undefined: hist[0]=0x0008.

Source files
------------

// File: rtl/histogram_builder.sv
// histogram_builder: streams packed pixel words and counts each 8-bit pixel
// value into 256 bins. When a frame is complete it pulses ac_we/done so that
// the downstream cumulative-sum block captures the bins.
// Optional build macro: HIST_SAT_EN makes bins saturate instead of wrap.
module histogram_builder #(
    parameter int LANES = 8,
    parameter int BIN_W = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_words,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [16*LANES-1:0]  in_data,
    output logic [BIN_W-1:0]     hist [256],
    output logic                 ac_we,
    output logic                 busy,
    output logic                 done
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_COUNT,
        S_FLUSH
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     words_left_q, words_left_d;
    logic [7:0]           idx_q, idx_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [8*LANES-1:0]   pix_q, pix_d;
    logic [BIN_W-1:0]     hist_q [256];

    logic                 clr_en;
    logic                 inc_en;
    logic [7:0]           pix_cur;
    logic [BIN_W-1:0]     bin_cur;
    logic [BIN_W-1:0]     bin_next;
    logic [8*LANES-1:0]   in_pix;
    logic [8*LANES-1:0]   unused_in_hi;

    // Split the incoming word into its pixel bytes; the upper byte of each lane carries nothing.
    always_comb begin
        in_pix       = '0;
        unused_in_hi = '0;
        for (int k = 0; k < LANES; k++) begin
            in_pix[8*k +: 8]       = in_data[16*k +: 8];
            unused_in_hi[8*k +: 8] = in_data[16*k+8 +: 8];
        end
    end

    // Select the pixel of the current lane and form its incremented bin value.
    always_comb begin
        pix_cur = pix_q[8*lane_q +: 8];
        bin_cur = hist_q[pix_cur];
`ifdef HIST_SAT_EN
        bin_next = (bin_cur == {BIN_W{1'b1}}) ? bin_cur : bin_cur + BIN_W'(1);
`else
        bin_next = bin_cur + BIN_W'(1);
`endif
    end

    // Control state and frame bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            words_left_q <= '0;
            idx_q        <= '0;
            lane_q       <= '0;
            pix_q        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q      <= state_d;
            words_left_q <= words_left_d;
            idx_q        <= idx_d;
            lane_q       <= lane_d;
            pix_q        <= pix_d;
        end
    end

    // Next-state and output decode; in_ready depends on the state only.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d      = state_q;
        words_left_d = words_left_q;
        idx_d        = idx_q;
        lane_d       = lane_q;
        pix_d        = pix_q;
        in_ready     = 1'b0;
        ac_we        = 1'b0;
        done         = 1'b0;
        clr_en       = 1'b0;
        inc_en       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    words_left_d = num_words;
                    idx_d        = '0;
                    state_d      = S_CLEAR;
                end
            end
            S_CLEAR: begin
                clr_en = 1'b1;
                idx_d  = idx_q + 8'd1;
                if (idx_q == 8'hFF) begin
                    state_d = (words_left_q != '0) ? S_FETCH : S_FLUSH;
                end
            end
            S_FETCH: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    pix_d   = in_pix;
                    lane_d  = '0;
                    if (words_left_q != '0) begin
                        words_left_d = words_left_q - CNT_W'(1);
                    end
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                inc_en = 1'b1;
                lane_d = lane_q + LANE_W'(1);
                if (lane_q == LANE_W'(LANES - 1)) begin
                    state_d = (words_left_q != '0) ? S_FETCH : S_FLUSH;
                end
            end
            S_FLUSH: begin
                ac_we   = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);

    // Bin storage: cleared one bin per cycle in CLEAR, one increment per cycle in COUNT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the bins are flops, not RAM, so an async reset of the whole array is legal and required.
            for (int v = 0; v < 256; v++) begin
                hist_q[v] <= '0;
            end
        end else if (clr_en) begin
            hist_q[idx_q] <= '0;
        end else if (inc_en) begin
            hist_q[pix_cur] <= bin_next;
        end
    end

`ifdef HIST_SAT_EN
    logic sat_sticky_q;
    logic unused_sat;

    // Debug-only sticky flag: set when an increment hits a full bin, cleared with the bins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_sticky_q <= 1'b0;
        end else if (clr_en) begin
            sat_sticky_q <= 1'b0;
        end else if (inc_en && (bin_cur == {BIN_W{1'b1}})) begin
            sat_sticky_q <= 1'b1;
        end
    end

    assign unused_sat = sat_sticky_q;
`endif

    assign hist = hist_q;

endmodule

// File: tb/tb_histogram_builder.sv
// tb_histogram_builder: directed frames with randomized pixel data, checked
// against a counting reference model (per-value occurrence totals).
module tb_histogram_builder;

    localparam int LANES = 8;
    localparam int BIN_W = 16;
    localparam int CNT_W = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [CNT_W-1:0]    num_words;
    logic                in_valid;
    logic                in_ready;
    logic [16*LANES-1:0] in_data;
    logic [BIN_W-1:0]    hist [256];
    logic                ac_we;
    logic                busy;
    logic                done;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int cnt [256];

    always #5 clk = ~clk;

    histogram_builder #(.LANES(LANES), .BIN_W(BIN_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_words (num_words),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .hist      (hist),
        .ac_we     (ac_we),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Expected bin value from an exact occurrence count.
    function automatic logic [BIN_W-1:0] exp_bin(input int c);
`ifdef HIST_SAT_EN
        return (c > 65535) ? 16'hFFFF : 16'(c);
`else
        return 16'(c % 65536);
`endif
    endfunction

    function automatic int hist_diffs();
        int d = 0;
        for (int v = 0; v < 256; v++) begin
            if (hist[v] !== exp_bin(cnt[v])) d++;
        end
        return d;
    endfunction

    function automatic int hist_sum();
        int s = 0;
        for (int v = 0; v < 256; v++) s += int'(hist[v]);
        return s;
    endfunction

    // kind 0: random, 1: ramp 0..7, 2: 0xAB with upper byte 0xFF, 3: all zero
    function automatic logic [16*LANES-1:0] make_word(input int kind);
        logic [16*LANES-1:0] w = '0;
        for (int k = 0; k < LANES; k++) begin
            case (kind)
                0:       w[16*k +: 16] = {8'($urandom), 8'($urandom_range(0, 31))};
                1:       w[16*k +: 16] = {8'h00, 8'(k)};
                2:       w[16*k +: 16] = 16'hFFAB;
                default: w[16*k +: 16] = 16'h0000;
            endcase
        end
        return w;
    endfunction

    // Runs one frame; poke >= 0 pulses a second start (num_words=5) at that cycle.
    task automatic run_frame(input string tag, input int n, input int kind, input int stall,
                             input int poke, output int lat, output int stall_bad);
        int                  sent = 0;
        int                  stall_left = stall;
        int                  cycles = 0;
        int                  budget = 256 + n * (LANES + 1) + stall + 50;
        bit                  have_word = 0;
        bit                  fire;
        logic [16*LANES-1:0] w = '0;
        lat = -1;
        stall_bad = 0;
        for (int v = 0; v < 256; v++) cnt[v] = 0;
        @(negedge clk);
        start = 1'b1;
        num_words = CNT_W'(n);
        while (cycles < budget) begin
            if (!have_word && sent < n) begin
                w = make_word(kind);
                have_word = 1;
            end
            in_valid = 1'b0;
            if (have_word) begin
                if (sent == 1 && in_ready && stall_left > 0) begin
                    stall_left--;
                    if (hist_diffs() != 0) stall_bad++;
                end else begin
                    in_valid = 1'b1;
                    in_data = w;
                end
            end
            fire = in_valid && in_ready;
            @(posedge clk);
            cycles++;
            if (fire) begin
                for (int k = 0; k < LANES; k++) cnt[w[16*k +: 8]]++;
                sent++;
                have_word = 0;
            end
            @(negedge clk);
            start = (cycles == poke);
            if (cycles == poke) num_words = CNT_W'(5);
            if (done) begin
                lat = cycles;
                break;
            end
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (lat < 0) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            check({tag, "_ac_we_with_done"}, 32'(ac_we), 1);
            @(negedge clk);
            check({tag, "_done_one_cycle"}, 32'({done, ac_we}), 0);
            check({tag, "_idle_after"}, 32'(busy), 0);
        end
    endtask

    initial begin
        int lat;
        int sb;
        int pre;
        int pulses;
        logic [16*LANES-1:0] w;

        rst = 1'b1;
        start = 1'b0;
        num_words = '0;
        in_valid = 1'b0;
        in_data = '0;
        #12;
        for (int v = 0; v < 256; v++) cnt[v] = 0;
        check("reset_hist", hist_diffs(), 0);
        check("reset_ctrl", 32'({busy, in_ready, done, ac_we}), 0);
        @(negedge clk);
        rst = 1'b0;

        // One word, lanes 0..7.
        run_frame("ramp", 1, 1, 0, -1, lat, sb);
        check("ramp_latency", lat, 266);
        check("ramp_hist", hist_diffs(), 0);
        check("ramp_bin3", 32'(hist[3]), 1);
        check("ramp_bin8", 32'(hist[8]), 0);
        repeat (10) @(negedge clk);
        check("ramp_hold", hist_diffs(), 0);

        // Two words of 0xAB with junk upper bytes.
        run_frame("ab", 2, 2, 0, -1, lat, sb);
        check("ab_latency", lat, 275);
        check("ab_binAB", 32'(hist[8'hAB]), 16);
        check("ab_binFF", 32'(hist[8'hFF]), 0);
        check("ab_hist", hist_diffs(), 0);

        // Random words with a 20-cycle source stall after the first word.
        run_frame("stall", 4, 0, 20, -1, lat, sb);
        check("stall_latency", lat, 256 + 4 * 9 + 1 + 20);
        check("stall_no_change", sb, 0);
        check("stall_hist", hist_diffs(), 0);

        // Empty frame, with a start pulse during CLEAR that must be ignored.
        run_frame("empty", 0, 0, 0, 100, lat, sb);
        check("empty_latency", lat, 257);
        check("empty_hist", hist_diffs(), 0);
        repeat (20) @(negedge clk);
        check("empty_restart_ignored", 32'(busy), 0);

        // Plain random frame.
        run_frame("rand", 6, 0, 0, -1, lat, sb);
        check("rand_latency", lat, 256 + 6 * 9 + 1);
        check("rand_hist", hist_diffs(), 0);

        // Reset in the middle of COUNT.
        @(negedge clk);
        start = 1'b1;
        num_words = CNT_W'(1);
        @(negedge clk);
        start = 1'b0;
        w = make_word(0);
        in_valid = 1'b1;
        in_data = w;
        for (int i = 0; i < 400; i++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        check("rst_mid_reached_fetch", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        pre = hist_sum();
        check("rst_mid_bins_nonzero", 32'(pre > 0), 1);
        #2 rst = 1'b1;
        #1;
        for (int v = 0; v < 256; v++) cnt[v] = 0;
        check("rst_mid_hist", hist_diffs(), 0);
        check("rst_mid_ctrl", 32'({busy, in_ready}), 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done || ac_we) pulses++;
        end
        check("rst_mid_no_strobe", pulses, 0);

        // 8193 zero words: 65544 increments of bin 0.
        run_frame("sat", 8193, 3, 0, -1, lat, sb);
        check("sat_latency", lat, 256 + 8193 * 9 + 1);
        check("sat_bin0_model", 32'(hist[0]), 32'(exp_bin(65544)));
`ifdef HIST_SAT_EN
        check("sat_bin0", 32'(hist[0]), 32'h0000FFFF);
`else
        check("sat_bin0", 32'(hist[0]), 32'h00000008);
`endif
        check("sat_hist", hist_diffs(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
